// File: rtl/mul_final_cpa.sv
// mul_final_cpa: final carry-propagate adder of the integer multiplier.
// Takes the sum/carry rows from the Wallace column slices and adds them in a
// 2-stage split-carry pipeline with a valid/ready handshake on both sides.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   upstream handshake (in_ready is combinational)
//   in_sum                sum row, bit i has weight 2^i
//   in_carry              carry row, bit i has weight 2^(i+1)
//   flush                 synchronous clear of both pipeline stages
//   out_valid / out_ready downstream handshake
//   out_prod              (in_sum + (in_carry << 1)) mod 2^WIDTH
module mul_final_cpa #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned LO_W  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_prod
);

  localparam int unsigned HI_W = WIDTH - LO_W;

  // Stage state
  logic            v1;
  logic            v2;
  logic [LO_W-1:0] lo_sum;
  logic            c1;
  logic [HI_W-1:0] a_hi;
  logic [HI_W-1:0] b_hi;

  // Combinational datapath / control
  logic [WIDTH-1:0] b_row;
  logic [LO_W:0]    lo_full;
  logic [HI_W-1:0]  hi_sum;
  logic             s1_free;
  logic             s2_free;
  logic             s1_en;
  logic             s2_en;
  logic             unused_carry_msb;

  // Carry row is shifted up one column; its top bit falls off the product.
  assign b_row            = {in_carry[WIDTH-2:0], 1'b0};
  assign unused_carry_msb = in_carry[WIDTH-1];

  assign lo_full = {1'b0, in_sum[LO_W-1:0]} + {1'b0, b_row[LO_W-1:0]};
  assign hi_sum  = a_hi + b_hi + HI_W'(c1);

  // Full-throughput handshake: a stage is free if empty or draining this edge.
  assign s2_free  = !v2 || out_ready;
  assign s1_free  = !v1 || s2_free;
  assign in_ready = s1_free;

  // Loads are suppressed during flush so out_prod only moves on a real S2 load.
  assign s1_en = in_valid && s1_free && !flush;
  assign s2_en = v1 && s2_free && !flush;

  assign out_valid = v2;

  // Valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= s1_en || (v1 && !s2_free);
      v2 <= (v1 && s2_free) || (v2 && !out_ready);
    end
  end

  // Stage 1: low segment summed, high halves carried forward unsummed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_sum <= '0;
      c1     <= 1'b0;
      a_hi   <= '0;
      b_hi   <= '0;
    end else if (s1_en) begin
      lo_sum <= lo_full[LO_W-1:0];
      c1     <= lo_full[LO_W];
      a_hi   <= in_sum[WIDTH-1:LO_W];
      b_hi   <= b_row[WIDTH-1:LO_W];
    end
  end

  // Stage 2: high segment absorbs the low carry, product is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_prod <= '0;
    end else if (s2_en) begin
      out_prod <= {hi_sum, lo_sum};
    end
  end

endmodule

// File: tb/tb_mul_final_cpa.sv
module tb_mul_final_cpa;

  localparam int unsigned W = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         flush;
  logic         out_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_prod;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [W-1:0] vs [5];
  logic [W-1:0] vc [5];
  logic [W-1:0] ve [5];

  always #5 clk = ~clk;

  mul_final_cpa #(.WIDTH(40), .LO_W(20)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_carry (in_carry),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prod (out_prod)
  );

  // Advance one rising edge and settle at the following falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_sum = '0; in_carry = '0;
    #12;
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b want 0", out_valid); err_cnt++;
    end
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b want 1", in_ready); err_cnt++;
    end
    vec_cnt++;
    if (out_prod !== 40'h0) begin
      $display("FAIL reset_out_prod: got %h want 0", out_prod); err_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    out_ready = 1'b1; in_valid = 1'b1;
    in_sum = 40'h00000_00005; in_carry = 40'h00000_00001;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      $display("FAIL single_in_ready: got %b want 1", in_ready); err_cnt++;
    end
    tick();
    in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL single_early_valid: got %b want 0", out_valid); err_cnt++;
    end
    tick();
    vec_cnt++;
    if (out_valid !== 1'b1 || out_prod !== 40'h00_0000_0007) begin
      $display("FAIL single_result: got v=%b p=%h want v=1 p=0000000007", out_valid, out_prod);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL single_pulse_end: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      err_cnt++;
    end
  endtask

  task automatic test_carry_split;
    out_ready = 1'b1; in_valid = 1'b1;
    in_sum = 40'h00000_FFFFF; in_carry = 40'h0;
    tick();
    in_sum = 40'h00000_FFFFF; in_carry = 40'h00000_00001;
    tick();
    in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b1 || out_prod !== 40'h00_000F_FFFF) begin
      $display("FAIL split_row1: got v=%b p=%h want v=1 p=00000fffff", out_valid, out_prod);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (out_valid !== 1'b1 || out_prod !== 40'h00_0010_0001) begin
      $display("FAIL split_row2: got v=%b p=%h want v=1 p=0000100001", out_valid, out_prod);
      err_cnt++;
    end
    tick();
  endtask

  task automatic test_wrap;
    out_ready = 1'b1; in_valid = 1'b1;
    in_sum = 40'hFF_FFFF_FFFF; in_carry = 40'h80_0000_0001;
    tick();
    in_valid = 1'b0;
    tick();
    vec_cnt++;
    if (out_valid !== 1'b1 || out_prod !== 40'h00_0000_0001) begin
      $display("FAIL wrap: got v=%b p=%h want v=1 p=0000000001", out_valid, out_prod);
      err_cnt++;
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    int oidx = 0;
    logic stalled = 1'b0;
    logic [W-1:0] held = '0;
    logic saw_block = 1'b0;
    for (int cyc = 0; cyc < 40 && oidx < 5; cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 6);
      in_valid = (idx < 5);
      if (idx < 5) begin
        in_sum = vs[idx]; in_carry = vc[idx];
      end
      #1;
      if (!in_ready) saw_block = 1'b1;
      if (stalled) begin
        vec_cnt++;
        if (out_valid !== 1'b1 || out_prod !== held) begin
          $display("FAIL stall_hold: got v=%b p=%h want v=1 p=%h", out_valid, out_prod, held);
          err_cnt++;
        end
      end
      if (out_valid && out_ready) begin
        vec_cnt++;
        if (out_prod !== ve[oidx]) begin
          $display("FAIL stream_out%0d: got %h want %h", oidx, out_prod, ve[oidx]);
          err_cnt++;
        end
        oidx++;
      end
      stalled = out_valid && !out_ready;
      held = out_prod;
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vec_cnt++;
    if (oidx != 5) begin
      $display("FAIL stream_count: got %0d want 5 (timeout)", oidx); err_cnt++;
    end
    vec_cnt++;
    if (saw_block !== 1'b1) begin
      $display("FAIL stream_backpressure: in_ready never dropped, got %b want 1", saw_block);
      err_cnt++;
    end
    tick();
  endtask

  task automatic test_simultaneous;
    out_ready = 1'b0; in_valid = 1'b1;
    in_sum = vs[0]; in_carry = vc[0];
    tick();
    in_sum = vs[1]; in_carry = vc[1];
    tick();
    in_sum = vs[2]; in_carry = vc[2];
    #1;
    vec_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      $display("FAIL sim_full: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
      err_cnt++;
    end
    out_ready = 1'b1;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_prod !== ve[0]) begin
      $display("FAIL sim_drain: got rdy=%b p=%h want rdy=1 p=%h", in_ready, out_prod, ve[0]);
      err_cnt++;
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b1 || out_prod !== ve[1] || in_ready !== 1'b0) begin
      $display("FAIL sim_shift: got v=%b p=%h rdy=%b want v=1 p=%h rdy=0",
               out_valid, out_prod, in_ready, ve[1]);
      err_cnt++;
    end
    out_ready = 1'b1;
    tick();
    vec_cnt++;
    if (out_valid !== 1'b1 || out_prod !== ve[2]) begin
      $display("FAIL sim_accepted: got v=%b p=%h want v=1 p=%h", out_valid, out_prod, ve[2]);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL sim_empty: got v=%b want 0", out_valid); err_cnt++;
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1;
    in_sum = vs[3]; in_carry = vc[3];
    tick();
    in_sum = vs[4]; in_carry = vc[4];
    tick();
    in_sum = vs[0]; in_carry = vc[0];
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_clear: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      err_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++;
      if (out_valid !== 1'b0) begin
        $display("FAIL flush_dropped%0d: got v=%b p=%h want v=0", i, out_valid, out_prod);
        err_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1; in_valid = 1'b1;
    in_sum = vs[0]; in_carry = vc[0];
    tick();
    in_sum = vs[1]; in_carry = vc[1];
    tick();
    in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b1 || out_prod !== ve[0]) begin
      $display("FAIL rst_mid_pre: got v=%b p=%h want v=1 p=%h", out_valid, out_prod, ve[0]);
      err_cnt++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b0 || out_prod !== 40'h0 || in_ready !== 1'b1) begin
      $display("FAIL rst_mid_async: got v=%b p=%h rdy=%b want v=0 p=0 rdy=1",
               out_valid, out_prod, in_ready);
      err_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL rst_mid_after: got v=%b want 0", out_valid); err_cnt++;
    end
  endtask

  initial begin
    // Hand-computed: ve = vs + (vc << 1), top carry bit dropped, mod 2^40.
    vs[0] = 40'h12_3456_789A; vc[0] = 40'h00_0000_0001; ve[0] = 40'h12_3456_789C;
    vs[1] = 40'h00_000F_FFFF; vc[1] = 40'h00_0000_0800; ve[1] = 40'h00_0010_0FFF;
    vs[2] = 40'h55_5555_5555; vc[2] = 40'h2A_AAAA_AAAA; ve[2] = 40'hAA_AAAA_AAA9;
    vs[3] = 40'h00_0000_0000; vc[3] = 40'h40_0000_0000; ve[3] = 40'h80_0000_0000;
    vs[4] = 40'hAB_CDEF_0123; vc[4] = 40'h00_0000_0010; ve[4] = 40'hAB_CDEF_0143;

    test_reset();
    test_single();
    test_carry_split();
    test_wrap();
    test_back_to_back();
    test_simultaneous();
    test_flush();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
